// File: rtl/regfile_dump_sequencer_if.sv
// Byte stream handshake from the dump sequencer to the debug UART TX.
interface regfile_dump_sequencer_if;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready;

  modport master (output o_tx_data, output o_tx_valid, input i_tx_ready);
  modport slave  (input o_tx_data, input o_tx_valid, output i_tx_ready);
endinterface

// File: rtl/regfile_dump_sequencer.sv
// Walks the register bank through one read port and streams every register,
// MSB byte first, over a valid/ready byte interface while holding o_busy.
module regfile_dump_sequencer #(
  parameter int unsigned NUMBER_OF_REGISTERS = 32,
  parameter int unsigned REGISTERS_SIZE      = 32
) (
  input  logic                                   i_clk,
  input  logic                                   i_reset,
  input  logic                                   i_start,
  input  logic                                   i_abort,
  input  logic [REGISTERS_SIZE-1:0]              i_reg_data,
  output logic [$clog2(NUMBER_OF_REGISTERS)-1:0] o_reg_addr,
  output logic                                   o_busy,
  output logic                                   o_done,
  regfile_dump_sequencer_if.master               tx
);

  localparam int unsigned ADDR_W = $clog2(NUMBER_OF_REGISTERS);
  localparam int unsigned BYTES  = REGISTERS_SIZE / 8;
  localparam int unsigned CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_NEXT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [ADDR_W-1:0]         addr_q,  addr_d;
  logic [REGISTERS_SIZE-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]          cnt_q,   cnt_d;

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          state_d = ST_LOAD;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        shift_d = i_reg_data;
        cnt_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx.i_tx_ready) begin
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            state_d = ST_NEXT;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = shift_q << 8;
          end
        end
      end
      ST_NEXT: begin
        if (addr_q == ADDR_W'(NUMBER_OF_REGISTERS - 1)) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
    if (i_abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      addr_d  = '0;
    end
  end

  assign o_reg_addr    = addr_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign tx.o_tx_valid = (state_q == ST_SEND);
  assign tx.o_tx_data  = shift_q[REGISTERS_SIZE-1 -: 8];

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Randomized self-checking bench: byte stream compared to a queue built from the bank contents.
module tb_regfile_dump_sequencer;

  localparam int unsigned NR = 32;
  localparam int unsigned NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] bank [NR];
  logic [31:0] reg_data;
  logic [4:0]  reg_addr;
  logic        busy, done;

  logic        s_start = 1'b0;
  logic [15:0] sbank [4];
  logic [15:0] s_reg_data;
  logic [1:0]  s_reg_addr;
  logic        s_busy, s_done;

  int total = 0;
  int bad   = 0;

  regfile_dump_sequencer_if tif ();
  regfile_dump_sequencer_if sif ();

  always #5 clk = ~clk;

  assign reg_data   = bank[reg_addr];
  assign s_reg_data = sbank[s_reg_addr];

  regfile_dump_sequencer #(.NUMBER_OF_REGISTERS(NR), .REGISTERS_SIZE(32)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_reg_data(reg_data), .o_reg_addr(reg_addr), .o_busy(busy), .o_done(done),
    .tx(tif.master)
  );

  regfile_dump_sequencer #(.NUMBER_OF_REGISTERS(4), .REGISTERS_SIZE(16)) dut_small (
    .i_clk(clk), .i_reset(rst), .i_start(s_start), .i_abort(1'b0),
    .i_reg_data(s_reg_data), .o_reg_addr(s_reg_addr), .o_busy(s_busy), .o_done(s_done),
    .tx(sif.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready always, 1 ready one cycle in three, 2 random ready.
  // abort_idx/reset_idx: byte index at which abort/reset hits, -1 for none.
  task automatic run_dump(input int mode, input int abort_idx, input int reset_idx, input bit hold);
    logic [7:0] exp_q [$];
    logic [7:0] prev_data = 8'h00;
    logic [31:0] w;
    bit   prev_stall = 1'b0;
    bit   finished = 1'b0;
    bit   seen_valid = 1'b0;
    bit   rdy;
    int   nbytes = 0;
    for (int r = 0; r < int'(NR); r++) begin
      w = bank[r];
      for (int b = 0; b < int'(NB); b++) exp_q.push_back(w[31 - 8*b -: 8]);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int cyc = 1; cyc <= 4000 && !finished; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("stall_valid", 32'(tif.o_tx_valid), 32'd1);
        check("stall_data", 32'(tif.o_tx_data), 32'(prev_data));
      end
      if (tif.o_tx_valid && !seen_valid) begin
        seen_valid = 1'b1;
        check("first_valid_cycle", 32'(cyc), 32'd2);
      end
      if (done) begin
        // DONE is entered NR*(NB+2) edges after the start edge.
        if (mode == 0) check("done_cycle", 32'(cyc - 1), 32'(NR * (NB + 2)));
        check("done_bytes", 32'(nbytes), 32'(NR * NB));
        finished = 1'b1;
      end else if (tif.o_tx_valid && nbytes == abort_idx) begin
        abort = 1'b1;
        tif.i_tx_ready = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        tif.i_tx_ready = 1'b0;
        check("abort_valid", 32'(tif.o_tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(reg_addr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        finished = 1'b1;
      end else if (tif.o_tx_valid && nbytes == reset_idx) begin
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(tif.o_tx_valid), 32'd0);
        check("rst_data", 32'(tif.o_tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        finished = 1'b1;
      end else begin
        rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
        tif.i_tx_ready = rdy;
        if (tif.o_tx_valid && rdy) begin
          check("byte", 32'(tif.o_tx_data), 32'(exp_q[nbytes]));
          nbytes++;
        end
        prev_stall = tif.o_tx_valid && !rdy;
        prev_data  = tif.o_tx_data;
      end
    end
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
    if (abort_idx < 0 && reset_idx < 0) begin
      @(negedge clk);
      check("idle_after_done_busy", 32'(busy), 32'd0);
      check("idle_after_done_pulse", 32'(done), 32'd0);
      if (hold) begin
        @(negedge clk);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_addr", 32'(reg_addr), 32'd0);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("restart_abort_busy", 32'(busy), 32'd0);
        abort = 1'b0;
      end
    end
    tif.i_tx_ready = 1'b0;
  endtask

  task automatic run_small;
    logic [15:0] w;
    logic [7:0]  eb;
    int  nbytes = 0;
    bit  finished = 1'b0;
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    for (int cyc = 1; cyc <= 60 && !finished; cyc++) begin
      @(negedge clk);
      if (sif.o_tx_valid) begin
        w  = sbank[nbytes / 2];
        eb = (nbytes % 2 == 0) ? w[15:8] : w[7:0];
        check("small_byte", 32'(sif.o_tx_data), 32'(eb));
        nbytes++;
      end
      if (s_done) begin
        check("small_done_cycle", 32'(cyc - 1), 32'd16);
        check("small_bytes", 32'(nbytes), 32'd8);
        finished = 1'b1;
      end
    end
    if (!finished) check("small_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("small_idle_busy", 32'(s_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.i_tx_ready = 1'b0;
    sif.i_tx_ready = 1'b1;
    for (int k = 0; k < int'(NR); k++) bank[k] = 32'h1000_0000 + 32'(k);
    for (int k = 0; k < 4; k++) sbank[k] = 16'($urandom);
    #23;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(tif.o_tx_valid), 32'd0);
    check("reset_data", 32'(tif.o_tx_data), 32'd0);
    check("reset_addr", 32'(reg_addr), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_dump(0, -1, -1, 1'b0);
    run_dump(1, -1, -1, 1'b0);

    bank[0] = 32'h0;
    bank[5] = 32'hDEAD_BEEF;
    run_dump(0, 5 * NB + 1, -1, 1'b0);
    run_dump(0, -1, -1, 1'b0);

    for (int k = 1; k < int'(NR); k++) bank[k] = $urandom;
    run_dump(2, -1, -1, 1'b0);
    run_dump(0, -1, -1, 1'b1);
    run_dump(2, -1, 40, 1'b0);
    run_dump(0, -1, -1, 1'b0);

    run_small();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
